// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions three raw, active-low, asynchronous pushbuttons into clean
// one-cycle strobes for an up/down counter.
//   Each button: 2-flop synchronizer -> saturating debounce counter ->
//   stable pressed level -> rising-edge press event -> priority arbitration
//   -> registered pulse.
//
// Optional feature (macro BTN_AUTOREPEAT_EN): an increment/decrement
// auto-repeat FSM (IDLE -> DELAY -> REPEAT). Without the macro there is
// exactly one pulse per debounced press.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing cycles before the stable state flips
//   REPEAT_DELAY     hold cycles before the first auto-repeat pulse
//   REPEAT_PERIOD    cycles between subsequent auto-repeat pulses
//
// Ports:
//   clk                single system clock, rising edge
//   rst_n              asynchronous active-low reset
//   btn_increment_raw  raw increment button, pressed = 0
//   btn_decrement_raw  raw decrement button, pressed = 0
//   btn_reset_raw      raw counter-clear button, pressed = 0
//   inc_pulse          one-cycle increment strobe
//   dec_pulse          one-cycle decrement strobe
//   clr_pulse          one-cycle clear strobe
//   btn_state          debounced pressed levels {reset, decrement, increment}
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_increment_raw,
  input  logic       btn_decrement_raw,
  input  logic       btn_reset_raw,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       clr_pulse,
  output logic [2:0] btn_state
);

  localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Bit order everywhere: [2]=clear, [1]=decrement, [0]=increment.
  logic [2:0]         raw_n;
  logic [2:0]         sync1_q, sync1_d;
  logic [2:0]         sync2_q, sync2_d;
  logic [2:0]         stable_q, stable_d;       // 1 = pressed
  logic [2:0]         stable_dly_q, stable_dly_d;
  logic [2:0][CW-1:0] cnt_q, cnt_d;
  logic               inc_pulse_q, inc_pulse_d;
  logic               dec_pulse_q, dec_pulse_d;
  logic               clr_pulse_q, clr_pulse_d;

  logic [2:0] evt;
  logic       accept_inc;
  logic       accept_dec;
  logic       accept_clr;
  logic       rep_inc;
  logic       rep_dec;

  assign raw_n = {btn_reset_raw, btn_decrement_raw, btn_increment_raw};

  // Synchronizers and debounce counters.
  always_comb begin
    sync1_d      = raw_n;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    cnt_d        = cnt_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (~sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= DB_LAST) begin
        // This cycle is the DEBOUNCE_CYCLES-th differing one: flip and clear.
        // The >= also keeps the counter from ever passing its limit.
        stable_d[i] = ~stable_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Press events: released->pressed only.
  assign evt = stable_q & ~stable_dly_q;

  // Clear wins; simultaneous inc+dec cancel each other.
  assign accept_clr = evt[2];
  assign accept_inc = evt[0] & ~evt[1] & ~evt[2];
  assign accept_dec = evt[1] & ~evt[0] & ~evt[2];

`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rep_state_e;

  localparam int unsigned   RMAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned   RW      = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  rep_state_e    state_q, state_d;
  logic          dir_q, dir_d;   // 0 = increment, 1 = decrement
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          held;
  logic          rep_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    rcnt_d   = rcnt_q;
    rep_fire = 1'b0;
    // Held means the tracked button alone is down (the other direction aborts).
    held = dir_q ? (stable_q[1] & ~stable_q[0]) : (stable_q[0] & ~stable_q[1]);
    if (accept_inc || accept_dec) begin
      state_d = ST_DELAY;
      dir_d   = accept_dec;
      rcnt_d  = '0;
    end else if (!held || accept_clr) begin
      state_d = ST_IDLE;
      rcnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_DELAY: begin
          if (rcnt_q >= RD_LAST) begin
            rep_fire = 1'b1;
            state_d  = ST_REPEAT;
            rcnt_d   = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
        ST_REPEAT: begin
          if (rcnt_q >= RP_LAST) begin
            rep_fire = 1'b1;
            rcnt_d   = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  assign rep_inc = rep_fire & ~dir_q;
  assign rep_dec = rep_fire &  dir_q;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep_inc = 1'b0;
  assign rep_dec = 1'b0;
`endif

  always_comb begin
    clr_pulse_d = accept_clr;
    inc_pulse_d = accept_inc | rep_inc;
    dec_pulse_d = accept_dec | rep_dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      stable_q     <= '0;
      stable_dly_q <= '0;
      cnt_q        <= '0;
      inc_pulse_q  <= 1'b0;
      dec_pulse_q  <= 1'b0;
      clr_pulse_q  <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
      inc_pulse_q  <= inc_pulse_d;
      dec_pulse_q  <= dec_pulse_d;
      clr_pulse_q  <= clr_pulse_d;
    end
  end

  assign inc_pulse = inc_pulse_q;
  assign dec_pulse = dec_pulse_q;
  assign clr_pulse = clr_pulse_q;
  assign btn_state = stable_q;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Directed self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=8, REPEAT_PERIOD=3. Expected pulse edges are hand-computed and
// held as bit masks indexed by edge number relative to the first edge that
// samples a new raw level. Define BTN_AUTOREPEAT_EN for both files to check
// the auto-repeat build.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic       btn_increment_raw;
  logic       btn_decrement_raw;
  logic       btn_reset_raw;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       clr_pulse;
  logic [2:0] btn_state;

  int          total;
  int          bad;
  int          ecount;
  logic [63:0] exp_inc;
  logic [63:0] exp_dec;
  logic [63:0] exp_clr;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .btn_increment_raw(btn_increment_raw),
    .btn_decrement_raw(btn_decrement_raw),
    .btn_reset_raw    (btn_reset_raw),
    .inc_pulse        (inc_pulse),
    .dec_pulse        (dec_pulse),
    .clr_pulse        (clr_pulse),
    .btn_state        (btn_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] at(input int e);
    logic [63:0] r;
    r    = '0;
    r[e] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance n edges, checking all three pulses against the masks each edge.
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ecount++;
      chk($sformatf("inc_pulse@%0d", ecount), 32'(inc_pulse), 32'(exp_inc[ecount]));
      chk($sformatf("dec_pulse@%0d", ecount), 32'(dec_pulse), 32'(exp_dec[ecount]));
      chk($sformatf("clr_pulse@%0d", ecount), 32'(clr_pulse), 32'(exp_clr[ecount]));
    end
  endtask

  task automatic start(input logic [63:0] mi, input logic [63:0] md, input logic [63:0] mc);
    ecount  = 0;
    exp_inc = mi;
    exp_dec = md;
    exp_clr = mc;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    btn_increment_raw = 1'b1;
    btn_decrement_raw = 1'b1;
    btn_reset_raw     = 1'b1;

    // Reset state.
    start('0, '0, '0);
    watch(3);
    chk("reset_btn_state", 32'(btn_state), 32'h0);
    rst_n = 1'b1;
    watch(4);
    chk("idle_btn_state", 32'(btn_state), 32'h0);

    // Increment held 20 cycles.
`ifdef BTN_AUTOREPEAT_EN
    start(at(7) | at(15) | at(18) | at(21) | at(24), '0, '0);
`else
    start(at(7), '0, '0);
`endif
    btn_increment_raw = 1'b0;
    watch(5);
    chk("inc_state_before_flip", 32'(btn_state), 32'h0);
    watch(1);
    chk("inc_state_after_flip", 32'(btn_state), 32'h1);
    watch(14);
    btn_increment_raw = 1'b1;
    watch(5);
    chk("inc_state_release_pending", 32'(btn_state), 32'h1);
    watch(1);
    chk("inc_state_released", 32'(btn_state), 32'h0);
    watch(6);

    // 3-cycle decrement glitch: no effect.
    start('0, '0, '0);
    btn_decrement_raw = 1'b0;
    watch(3);
    btn_decrement_raw = 1'b1;
    watch(10);
    chk("glitch_btn_state", 32'(btn_state), 32'h0);

    // Clear and increment together: clear wins.
    start('0, '0, at(7));
    btn_reset_raw     = 1'b0;
    btn_increment_raw = 1'b0;
    watch(20);
    chk("clr_inc_state", 32'(btn_state), 32'h5);
    btn_reset_raw     = 1'b1;
    btn_increment_raw = 1'b1;
    watch(10);
    chk("clr_inc_released", 32'(btn_state), 32'h0);

    // Increment and decrement together: both suppressed.
    start('0, '0, '0);
    btn_increment_raw = 1'b0;
    btn_decrement_raw = 1'b0;
    watch(20);
    chk("inc_dec_state", 32'(btn_state), 32'h3);
    btn_increment_raw = 1'b1;
    btn_decrement_raw = 1'b1;
    watch(10);
    chk("inc_dec_released", 32'(btn_state), 32'h0);

    // Reset asserted at debounce count 2 while increment is held.
    start('0, '0, '0);
    btn_increment_raw = 1'b0;
    watch(4);
    rst_n = 1'b0;
    #1;
    chk("midreset_state_async", 32'(btn_state), 32'h0);
    watch(1);
    chk("midreset_state_e1", 32'(btn_state), 32'h0);
    watch(1);
    chk("midreset_state_e2", 32'(btn_state), 32'h0);
    rst_n = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
    start(at(7) | at(15) | at(18), '0, '0);
`else
    start(at(7), '0, '0);
`endif
    watch(12);
    chk("postreset_state", 32'(btn_state), 32'h1);
    btn_increment_raw = 1'b1;
    watch(12);
    chk("postreset_released", 32'(btn_state), 32'h0);

    // Increment held 30 cycles: repeat timing or single pulse.
`ifdef BTN_AUTOREPEAT_EN
    start(at(7) | at(15) | at(18) | at(21) | at(24) | at(27) | at(30) | at(33) | at(36),
          '0, '0);
`else
    start(at(7), '0, '0);
`endif
    btn_increment_raw = 1'b0;
    watch(30);
    btn_increment_raw = 1'b1;
    watch(10);
    chk("hold30_released", 32'(btn_state), 32'h0);

    // Decrement held 12 cycles.
`ifdef BTN_AUTOREPEAT_EN
    start('0, at(7) | at(15) | at(18), '0);
`else
    start('0, at(7), '0);
`endif
    btn_decrement_raw = 1'b0;
    watch(12);
    chk("dec_state", 32'(btn_state), 32'h2);
    btn_decrement_raw = 1'b1;
    watch(12);
    chk("dec_released", 32'(btn_state), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
